// File: rtl/lut_reverse_search.sv
// lut_reverse_search: writable key/data table with a one-entry-per-cycle data-to-key reverse lookup.
// Define REV_LUT_EARLY_EXIT_EN to end the scan at the first matching entry.
module lut_reverse_search #(
  parameter int NR_KEY = 4,
  parameter int KEY_LEN = 4,
  parameter int DATA_LEN = 8,
  parameter int DEFAULT_KEY = 0,
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
  localparam int IDX_W = NR_KEY > 1 ? $clog2(NR_KEY) : 1
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [KEY_LEN-1:0]         wr_key,
  input  logic [DATA_LEN-1:0]        wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [DATA_LEN-1:0]        req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_hit,
  output logic [KEY_LEN-1:0]         resp_key,
  output logic [IDX_W-1:0]           resp_idx,
  output logic                       busy,
  output logic [NR_KEY*PAIR_LEN-1:0] lut_out
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [KEY_LEN-1:0] keys [NR_KEY];
  logic [DATA_LEN-1:0] datas [NR_KEY];
  logic [NR_KEY-1:0] vld;
  logic [DATA_LEN-1:0] target;
  logic [IDX_W-1:0] idx;
  logic match, last, stop, accept;
  assign req_ready = state == IDLE;
  assign resp_valid = state == DONE;
  assign busy = state != IDLE;
  assign accept = req_valid && req_ready;
  assign match = vld[idx] && datas[idx] == target;
  assign last = idx == IDX_W'(NR_KEY - 1);
`ifdef REV_LUT_EARLY_EXIT_EN
  assign stop = last || match;
`else
  assign stop = last;
`endif
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req_valid ? SCAN : IDLE) :
              state == SCAN ? (stop ? DONE : SCAN) :
              (resp_ready ? IDLE : DONE);
  end
  // The table only changes while idle so a pending scan or held result never sees it move.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      vld <= '0;
      for (int n = 0; n < NR_KEY; n++) begin
        keys[n] <= '0;
        datas[n] <= '0;
      end
    end else if (wr_en && state == IDLE && 32'(wr_idx) < NR_KEY) begin
      keys[wr_idx] <= wr_key;
      datas[wr_idx] <= wr_data;
      vld[wr_idx] <= 1'b1;
    end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      target <= '0;
      idx <= '0;
      resp_hit <= 1'b0;
      resp_key <= '0;
      resp_idx <= '0;
    end else if (accept) begin
      target <= req_data;
      idx <= '0;
      resp_hit <= 1'b0;
      resp_key <= KEY_LEN'(DEFAULT_KEY);
      resp_idx <= '0;
    end else if (state == SCAN) begin
      idx <= last ? idx : idx + 1'b1;
      if (match && !resp_hit) begin
        resp_hit <= 1'b1;
        resp_key <= keys[idx];
        resp_idx <= idx;
      end
    end
  for (genvar g = 0; g < NR_KEY; g++) begin : g_pair
    assign lut_out[PAIR_LEN*g +: PAIR_LEN] = vld[g] ? {keys[g], datas[g]} : '0;
  end
endmodule

// File: tb/tb_lut_reverse_search.sv
// tb_lut_reverse_search: table vectors, corner sequences and random traffic against a table model.
module tb_lut_reverse_search;
  localparam int NR = 4;
  logic clk = 0, clrn = 0, wr_en = 0, req_valid = 0, resp_ready = 0;
  logic [1:0] wr_idx = 0;
  logic [3:0] wr_key = 0;
  logic [7:0] wr_data = 0, req_data = 0;
  logic req_ready, resp_valid, resp_hit, busy;
  logic [3:0] resp_key;
  logic [1:0] resp_idx;
  logic [47:0] lut_out;
  int checks = 0, errors = 0;
  logic [3:0] m_key [NR];
  logic [7:0] m_data [NR];
  logic m_vld [NR];
  typedef struct {
    logic wr; logic [1:0] idx; logic [3:0] key; logic [7:0] data;
    logic [7:0] req; logic hit; logic [3:0] ekey; logic [1:0] eidx;
  } vec_t;
  vec_t vecs [6];
  always #5 clk = ~clk;
  lut_reverse_search dut (
    .clk(clk), .clrn(clrn), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_key(resp_key), .resp_idx(resp_idx),
    .busy(busy), .lut_out(lut_out)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask
  function automatic logic [47:0] model_lut();
    logic [47:0] r = '0;
    for (int n = 0; n < NR; n++)
      if (m_vld[n]) r = r | (48'({m_key[n], m_data[n]}) << (12 * n));
    return r;
  endfunction
  function automatic void ref_search(input logic [7:0] d, output logic h, output logic [3:0] k, output logic [1:0] i);
    h = 0; k = 4'd0; i = 0;
    for (int n = NR - 1; n >= 0; n--)
      if (m_vld[n] && m_data[n] == d) begin h = 1; k = m_key[n]; i = 2'(n); end
  endfunction
  function automatic int exp_lat(input logic h, input logic [1:0] i);
`ifdef REV_LUT_EARLY_EXIT_EN
    return h ? int'(i) + 1 : NR;
`else
    return NR;
`endif
  endfunction
  task automatic clear_model();
    for (int n = 0; n < NR; n++) begin m_key[n] = 0; m_data[n] = 0; m_vld[n] = 0; end
  endtask
  task automatic wr(input logic [1:0] i, input logic [3:0] k, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_idx = i; wr_key = k; wr_data = d;
    @(negedge clk);
    wr_en = 0;
    m_key[i] = k; m_data[i] = d; m_vld[i] = 1;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic search(input string nm, input logic [7:0] d, input logic eh, input logic [3:0] ek, input logic [1:0] ei);
    int lat;
    @(negedge clk);
    req_data = d; req_valid = 1;
    chk({nm, "_req_ready"}, req_ready, 1);
    @(posedge clk); #1 req_valid = 0;
    wait_resp(lat);
    chk({nm, "_latency"}, lat, exp_lat(eh, ei));
    chk({nm, "_hit"}, resp_hit, eh);
    chk({nm, "_key"}, resp_key, ek);
    chk({nm, "_idx"}, resp_idx, ei);
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    chk({nm, "_idle_valid"}, resp_valid, 0);
    chk({nm, "_idle_busy"}, busy, 0);
  endtask
  task automatic search_model(input string nm, input logic [7:0] d);
    logic h; logic [3:0] k; logic [1:0] i;
    ref_search(d, h, k, i);
    search(nm, d, h, k, i);
  endtask
  initial begin
    int lat;
    logic [7:0] d;
    clear_model();
    vecs[0] = '{0, 0, 4'h0, 8'h00, 8'h00, 0, 4'h0, 0};
    vecs[1] = '{1, 0, 4'h3, 8'hA5, 8'hA5, 1, 4'h3, 0};
    vecs[2] = '{1, 2, 4'h7, 8'h3C, 8'h3C, 1, 4'h7, 2};
    vecs[3] = '{1, 1, 4'h1, 8'h55, 8'h3C, 1, 4'h7, 2};
    vecs[4] = '{1, 3, 4'h9, 8'h55, 8'h55, 1, 4'h1, 1};
    vecs[5] = '{0, 0, 4'h0, 8'h00, 8'h77, 0, 4'h0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lut", lut_out, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", {resp_hit, resp_key, resp_idx}, 0);
    @(negedge clk) clrn = 1;
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].wr) wr(vecs[v].idx, vecs[v].key, vecs[v].data);
      search($sformatf("vec%0d", v), vecs[v].req, vecs[v].hit, vecs[v].ekey, vecs[v].eidx);
    end
    chk("lut_pair2", lut_out[35:24], 12'h73C);
    chk("lut_all", lut_out, model_lut());
    @(negedge clk);
    req_data = 8'h55; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    wait_resp(lat);
    chk("bp_latency", lat, exp_lat(1, 1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      wr_en = c == 1; wr_idx = 0; wr_key = 4'hF; wr_data = 8'hFF;
      chk("bp_valid", resp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_resp", {resp_hit, resp_key, resp_idx}, {1'b1, 4'h1, 2'd1});
    end
    wr_en = 0;
    chk("bp_lut_unchanged", lut_out, model_lut());
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", req_ready, 1);
    @(negedge clk);
    wr_en = 1; wr_idx = 1; wr_key = 4'h2; wr_data = 8'h11;
    req_valid = 1; req_data = 8'h11;
    @(posedge clk); #1 wr_en = 0; req_valid = 0;
    m_key[1] = 4'h2; m_data[1] = 8'h11; m_vld[1] = 1;
    wait_resp(lat);
    chk("same_latency", lat, exp_lat(1, 1));
    chk("same_resp", {resp_hit, resp_key, resp_idx}, {1'b1, 4'h2, 2'd1});
    resp_ready = 1;
    @(posedge clk); #1 resp_ready = 0;
    @(negedge clk);
    req_data = 8'h3C; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 clrn = 0;
    #1;
    chk("abort_valid", resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lut", lut_out, 0);
    chk("abort_req_ready", req_ready, 1);
    clear_model();
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_resp", resp_valid, 0);
    end
    @(negedge clk) clrn = 1;
    search("post_reset", 8'h3C, 0, 4'h0, 0);
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 2)) wr(2'($urandom_range(0, 3)), 4'($urandom), 8'h10 + 8'($urandom_range(0, 3)));
      d = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom_range(0, 3));
      search_model($sformatf("rand%0d", r), d);
    end
    chk("rand_lut", lut_out, model_lut());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end
endmodule
